mul_rr_scheduler: RTL and testbench

//  Shares one 64x64 signed radix-4 Booth multiplier (op_start/op_clear/op_done

---
 rtl/mul_rr_scheduler.sv | 150 +++++++++++++++
 tb/tb_mul_rr_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_scheduler.sv
// Round-robin front end that time-shares one 64x64 signed Booth multiplier among NREQ requesters.
// One operation is in flight at a time: grant, start, wait (with watchdog), respond, clear.
module mul_rr_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 40
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*64-1:0]   req_a,
    input  logic [NREQ*64-1:0]   req_b,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [127:0]         rsp_result,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [63:0]          mul_multiplier,
    output logic [63:0]          mul_multiplicand,
    output logic                 mul_op_start,
    output logic                 mul_op_clear,
    input  logic                 mul_op_done,
    input  logic [127:0]         mul_result
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        RESP,
        CLEAR
    } state_t;

    state_t            state;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    cur_id;
    logic [WDW-1:0]    wdog;

    logic              found;
    logic [IDW-1:0]    win_id;
    logic [IDW-1:0]    next_ptr;
    logic [NREQ-1:0]   win_oh;
    logic [63:0]       win_a;
    logic [63:0]       win_b;

    // Rotating priority: distance k from the pointer is scanned first, so the
    // search order is ptr, ptr+1, ... wrapping at NREQ.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        win_oh = '0;
        win_a  = '0;
        win_b  = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && ((int'(ptr) + k) % NREQ) == j) begin
                    found  = 1'b1;
                    win_id = IDW'(j);
                end
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            win_oh[j] = found && (win_id == IDW'(j));
            if (win_oh[j]) begin
                win_a = req_a[j*64 +: 64];
                win_b = req_b[j*64 +: 64];
            end
        end
        next_ptr = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            ptr              <= '0;
            cur_id           <= '0;
            wdog             <= '0;
            gnt              <= '0;
            rsp_valid        <= 1'b0;
            rsp_id           <= '0;
            rsp_result       <= '0;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            mul_op_start     <= 1'b0;
            mul_op_clear     <= 1'b0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt              <= win_oh;
                        mul_multiplier   <= win_a;
                        mul_multiplicand <= win_b;
                        cur_id           <= win_id;
                        ptr              <= next_ptr;
                        mul_op_start     <= 1'b1;
                        busy             <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    mul_op_start <= 1'b0;
                    wdog         <= WDW'(1);
                    state        <= WAIT;
                end
                // A late op_done on the very cycle the watchdog expires still wins.
                WAIT: begin
                    if (mul_op_done) begin
                        rsp_result <= mul_result;
                        rsp_err    <= 1'b0;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (wdog == WDW'(TIMEOUT)) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_id     <= cur_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid    <= 1'b0;
                        mul_op_clear <= 1'b1;
                        wdog         <= '0;
                        state        <= CLEAR;
                    end
                end
                CLEAR: begin
                    mul_op_clear <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Bench for mul_rr_scheduler: behavioural multiplier model plus a grant-time scoreboard
// checked at every response handshake.
module tb_mul_rr_scheduler;

    typedef struct {
        logic [1:0]   id;
        logic [127:0] result;
        logic         err;
    } rsp_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [3:0]     req;
    logic [255:0]   req_a;
    logic [255:0]   req_b;
    logic [3:0]     gnt;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [127:0]   rsp_result;
    logic           rsp_err;
    logic           busy;
    logic [63:0]    mul_multiplier;
    logic [63:0]    mul_multiplicand;
    logic           mul_op_start;
    logic           mul_op_clear;
    logic           mul_op_done;
    logic [127:0]   mul_result;

    int             n_checks = 0;
    int             n_fail = 0;
    int             cyc = 0;
    bit             stuck = 1'b0;
    logic [127:0]   model_prod;
    int             model_cnt;

    rsp_t           sb_q[$];
    int             gnt_q[$];
    int             rsp_count = 0;
    int             gnt_cycle = 0;
    int             valid_cycle = 0;
    logic           prev_valid = 1'b0;
    logic           clear_pending = 1'b0;
    logic [1:0]     last_id;
    logic [127:0]   last_result;
    logic           last_err;

    mul_rr_scheduler #(.NREQ(4), .IDW(2), .TIMEOUT(40)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req              (req),
        .req_a            (req_a),
        .req_b            (req_b),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_id           (rsp_id),
        .rsp_result       (rsp_result),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_op_start     (mul_op_start),
        .mul_op_clear     (mul_op_clear),
        .mul_op_done      (mul_op_done),
        .mul_result       (mul_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] mulRef(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sa;
        logic signed [127:0] sb;
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        return sa * sb;
    endfunction

    function automatic int gntIndex(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (g[i]) r = i;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Multiplier stand-in: done 32 edges after start unless stuck; done held until clear.
    always @(posedge clk) begin
        if (!reset_n) begin
            mul_op_done <= 1'b0;
            model_cnt   <= 0;
            model_prod  <= '0;
        end else if (mul_op_clear) begin
            mul_op_done <= 1'b0;
            model_cnt   <= 0;
        end else if (mul_op_start) begin
            model_prod <= mulRef(mul_multiplier, mul_multiplicand);
            model_cnt  <= 32;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1 && !stuck) mul_op_done <= 1'b1;
        end
    end

    assign mul_result = mul_op_done ? model_prod : '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid    <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            checkOutput("start_clear_excl", 128'(mul_op_start & mul_op_clear), 128'd0);
            if (clear_pending) checkOutput("clear_after_hs", 128'(mul_op_clear), 128'd1);
            clear_pending <= rsp_valid && rsp_ready;
            if (gnt != 4'd0) begin
                rsp_t e;
                int   g;
                checkOutput("gnt_onehot", 128'($onehot(gnt)), 128'd1);
                g = gntIndex(gnt);
                gnt_q.push_back(g);
                e.id     = 2'(g);
                e.result = stuck ? 128'd0 : mulRef(req_a[g*64 +: 64], req_b[g*64 +: 64]);
                e.err    = stuck;
                sb_q.push_back(e);
                gnt_cycle <= cyc;
            end
            if (rsp_valid && !prev_valid) valid_cycle <= cyc;
            prev_valid <= rsp_valid;
            if (rsp_valid && rsp_ready) begin
                checkOutput("sb_nonempty", 128'(sb_q.size() > 0), 128'd1);
                if (sb_q.size() > 0) begin
                    rsp_t e;
                    e = sb_q.pop_front();
                    checkOutput("rsp_id", 128'(rsp_id), 128'(e.id));
                    checkOutput("rsp_result", rsp_result, e.result);
                    checkOutput("rsp_err", 128'(rsp_err), 128'(e.err));
                end
                last_id     <= rsp_id;
                last_result <= rsp_result;
                last_err    <= rsp_err;
                rsp_count   <= rsp_count + 1;
            end
        end
    end

    task automatic applyStimulus(input int idx, input logic [63:0] a, input logic [63:0] b);
        req_a[idx*64 +: 64] = a;
        req_b[idx*64 +: 64] = b;
        req[idx] = 1'b1;
    endtask

    task automatic waitGrant(input int idx);
        int  k;
        bit  got;
        k = 0;
        got = 1'b0;
        while (!got && k < 200) begin
            @(negedge clk);
            if (gnt[idx]) got = 1'b1;
            k++;
        end
        checkOutput($sformatf("grant%0d_seen", idx), 128'(got), 128'd1);
        @(negedge clk);
        checkOutput($sformatf("grant%0d_pulse", idx), 128'(gnt), 128'd0);
        @(posedge clk);
        #1 req[idx] = 1'b0;
    endtask

    task automatic waitRsp(input int target);
        int k;
        k = 0;
        while (rsp_count < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput("rsp_arrived", 128'(rsp_count >= target), 128'd1);
    endtask

    task automatic runOp(input int idx, input logic [63:0] a, input logic [63:0] b);
        int target;
        target = rsp_count + 1;
        applyStimulus(idx, a, b);
        waitGrant(idx);
        waitRsp(target);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_gnt"}, 128'(gnt), 128'd0);
        checkOutput({tag, "_valid"}, 128'(rsp_valid), 128'd0);
        checkOutput({tag, "_id"}, 128'(rsp_id), 128'd0);
        checkOutput({tag, "_result"}, rsp_result, 128'd0);
        checkOutput({tag, "_err"}, 128'(rsp_err), 128'd0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
        checkOutput({tag, "_mplier"}, 128'(mul_multiplier), 128'd0);
        checkOutput({tag, "_mcand"}, 128'(mul_multiplicand), 128'd0);
        checkOutput({tag, "_start"}, 128'(mul_op_start), 128'd0);
        checkOutput({tag, "_clear"}, 128'(mul_op_clear), 128'd0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sb_q.delete();
        gnt_q.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int base;
        int k;

        reset_n   = 1'b0;
        req       = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk);
        #1 reset_n = 1'b1;

        // T1: single requester, small positive product
        runOp(0, 64'd3, 64'd5);
        checkOutput("t1_id", 128'(last_id), 128'd0);
        checkOutput("t1_result", last_result, 128'd15);
        checkOutput("t1_err", 128'(last_err), 128'd0);
        checkOutput("t1_latency_le36", 128'((valid_cycle - gnt_cycle) <= 36), 128'd1);

        // T2: sign handling and the most-negative operand
        runOp(2, -64'sd7, 64'd6);
        checkOutput("t2a_id", 128'(last_id), 128'd2);
        checkOutput("t2a_result", last_result, {{64{1'b1}}, 64'hFFFF_FFFF_FFFF_FFD6});
        runOp(2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("t2b_result", last_result, {64'd0, 64'h8000_0000_0000_0000});

        // T3: all requesters held high from pointer 0
        doReset();
        base = rsp_count;
        for (int i = 0; i < 4; i++) begin
            req_a[i*64 +: 64] = 64'(i * 1000 + 17);
            req_b[i*64 +: 64] = -64'(i + 3);
        end
        @(posedge clk);
        #1 req = 4'hF;
        k = 0;
        while (gnt_q.size() < 5 && k < 400) begin
            @(negedge clk);
            k++;
        end
        checkOutput("t3_grant_count", 128'(gnt_q.size() >= 5), 128'd1);
        @(posedge clk);
        #1 req = 4'h0;
        waitRsp(base + 5);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t3_order%0d", i),
                        128'((i < gnt_q.size()) ? gnt_q[i] : 99), 128'(exp_order[i]));
        end

        // T4: consumer stalls in RESP while another requester waits
        base = rsp_count;
        rsp_ready = 1'b0;
        applyStimulus(1, 64'd123456789, -64'sd987);
        waitGrant(1);
        applyStimulus(3, 64'd11, 64'd13);
        k = 0;
        while (!rsp_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t4_valid", 128'(rsp_valid), 128'd1);
            checkOutput("t4_id", 128'(rsp_id), 128'd1);
            checkOutput("t4_result", rsp_result, mulRef(64'd123456789, -64'sd987));
            checkOutput("t4_no_gnt", 128'(gnt), 128'd0);
            checkOutput("t4_no_clear", 128'(mul_op_clear), 128'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        waitRsp(base + 1);
        waitGrant(3);
        waitRsp(base + 2);
        checkOutput("t4_second_id", 128'(last_id), 128'd3);
        checkOutput("t4_second_result", last_result, 128'd143);

        // T5: multiplier never finishes, watchdog aborts
        stuck = 1'b1;
        runOp(2, 64'd5, 64'd7);
        checkOutput("t5_err", 128'(last_err), 128'd1);
        checkOutput("t5_result", last_result, 128'd0);
        checkOutput("t5_latency", 128'(valid_cycle - gnt_cycle), 128'd41);
        stuck = 1'b0;
        runOp(0, 64'd9, -64'sd3);
        checkOutput("t5_recover_err", 128'(last_err), 128'd0);
        checkOutput("t5_recover_result", last_result, {{64{1'b1}}, -64'sd27});

        // T6: reset in the middle of WAIT abandons the op and rewinds the pointer
        applyStimulus(1, 64'd2, 64'd2);
        waitGrant(1);
        repeat (10) @(negedge clk);
        checkOutput("t6_busy_before", 128'(busy), 128'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        sb_q.delete();
        gnt_q.delete();
        @(negedge clk);
        checkResetState("t6");
        base = rsp_count;
        @(posedge clk);
        #1 req = 4'hF;
        k = 0;
        while (gnt_q.size() < 1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req = 4'h0;
        checkOutput("t6_first_gnt", 128'((gnt_q.size() > 0) ? gnt_q[0] : 99), 128'd0);
        waitRsp(base + 1);
        checkOutput("t6_rsp_count", 128'(rsp_count - base), 128'd1);

        repeat (5) @(negedge clk);
        checkOutput("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
